// File: rtl/sprite_anim_ctrl.sv
// rtl/sprite_anim_ctrl.sv - fighter pose sequencer and mirrored sprite ROM address generator
// Pose/facing advance once per frame_tick; address path is one register stage behind the raster.
module sprite_anim_ctrl #(
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int FRAMES_PER_STEP = 6,
  parameter int ADDR_W          = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              left,
  input  logic              right,
  input  logic              on_ground,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
  output logic [1:0]        sprite_sel,
  output logic              facing_left,
  output logic              in_sprite,
  output logic [ADDR_W-1:0] rom_addr
);

  localparam int CNT_W = $clog2(FRAMES_PER_STEP);
  localparam int XW    = $clog2(SPRITE_W);
  localparam int YW    = ADDR_W - XW;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [10:0] W11 = 11'(SPRITE_W);
  localparam logic [10:0] H11 = 11'(SPRITE_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN1 = 2'd1,
    RUN2 = 2'd2,
    AIR  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      facing_left <= 1'b0;
    end else if (frame_tick) begin
      if (!on_ground) begin
        state <= AIR;
        cnt   <= '0;
      end else if (left ^ right) begin
        if (state == RUN1 || state == RUN2) begin
          if (cnt == LAST_CNT) begin
            state <= (state == RUN1) ? RUN2 : RUN1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          state <= RUN1;
          cnt   <= '0;
        end
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end

      if (left && !right) begin
        facing_left <= 1'b1;
      end else if (right && !left) begin
        facing_left <= 1'b0;
      end
    end
  end

  assign sprite_sel = state;

  // Low bits of the offsets depend only on low bits of the operands; compares use 11 bits to avoid wrap.
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic [XW-1:0] col;
  logic          hit;

  always_comb begin
    dx  = DrawX[XW-1:0] - PosX[XW-1:0];
    dy  = DrawY[YW-1:0] - PosY[YW-1:0];
    col = facing_left ? ~dx : dx;  // ~dx == SPRITE_W-1-dx for power-of-two width
    hit = ({1'b0, DrawX} >= {1'b0, PosX}) && ({1'b0, DrawX} < ({1'b0, PosX} + W11)) &&
          ({1'b0, DrawY} >= {1'b0, PosY}) && ({1'b0, DrawY} < ({1'b0, PosY} + H11));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_sprite <= 1'b0;
      rom_addr  <= '0;
    end else begin
      in_sprite <= hit;
      rom_addr  <= hit ? {dy, col} : '0;
    end
  end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// tb/tb_sprite_anim_ctrl.sv - directed self-checking bench for sprite_anim_ctrl
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 time unit after a rising edge.
module tb_sprite_anim_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic       frame_tick;
  logic       left;
  logic       right;
  logic       on_ground;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] PosX;
  logic [9:0] PosY;
  logic [1:0] sprite_sel;
  logic       facing_left;
  logic       in_sprite;
  logic [9:0] rom_addr;

  int total = 0;
  int bad   = 0;

  sprite_anim_ctrl #(
    .SPRITE_W(32), .SPRITE_H(32), .FRAMES_PER_STEP(6), .ADDR_W(10)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .left(left), .right(right), .on_ground(on_ground),
    .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
    .sprite_sel(sprite_sel), .facing_left(facing_left),
    .in_sprite(in_sprite), .rom_addr(rom_addr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic do_tick(input logic l, input logic r, input logic g);
    @(negedge Clk);
    left = l; right = r; on_ground = g; frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic set_raster(input logic [9:0] dxv, input logic [9:0] dyv,
                            input logic [9:0] pxv, input logic [9:0] pyv);
    @(negedge Clk);
    DrawX = dxv; DrawY = dyv; PosX = pxv; PosY = pyv;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; frame_tick = 1'b0; left = 1'b0; right = 1'b0; on_ground = 1'b1;
    DrawX = 10'd0; DrawY = 10'd0; PosX = 10'd500; PosY = 10'd500;
    #1;
    total++; if (sprite_sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d expected 0", sprite_sel); end
    total++; if (facing_left !== 1'b0) begin bad++; $display("FAIL reset_face: got %0d expected 0", facing_left); end
    total++; if (in_sprite !== 1'b0) begin bad++; $display("FAIL reset_in: got %0d expected 0", in_sprite); end
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0, 1'b0, 1'b1);
      total++; if (sprite_sel !== 2'd0) begin bad++; $display("FAIL idle_sel[%0d]: got %0d expected 0", i, sprite_sel); end
      total++; if (facing_left !== 1'b0) begin bad++; $display("FAIL idle_face[%0d]: got %0d expected 0", i, facing_left); end
    end
    // left held without a tick must be ignored
    @(negedge Clk);
    left = 1'b1;
    repeat (3) @(negedge Clk);
    total++; if (facing_left !== 1'b0) begin bad++; $display("FAIL no_tick_face: got %0d expected 0", facing_left); end
    total++; if (sprite_sel !== 2'd0) begin bad++; $display("FAIL no_tick_sel: got %0d expected 0", sprite_sel); end
    left = 1'b0;
  endtask

  task automatic test_run_cycle;
    logic [1:0] exp_sel;
    for (int i = 1; i <= 13; i++) begin
      do_tick(1'b0, 1'b1, 1'b1);
      exp_sel = (i <= 6) ? 2'd1 : (i <= 12) ? 2'd2 : 2'd1;
      total++; if (sprite_sel !== exp_sel) begin bad++; $display("FAIL run_sel[%0d]: got %0d expected %0d", i, sprite_sel, exp_sel); end
      total++; if (facing_left !== 1'b0) begin bad++; $display("FAIL run_face[%0d]: got %0d expected 0", i, facing_left); end
    end
  endtask

  task automatic test_air_reentry;
    // currently RUN1 with counter 0: six more ticks reach RUN2
    for (int i = 0; i < 6; i++) do_tick(1'b0, 1'b1, 1'b1);
    total++; if (sprite_sel !== 2'd2) begin bad++; $display("FAIL pre_air_sel: got %0d expected 2", sprite_sel); end
    do_tick(1'b0, 1'b1, 1'b0);
    total++; if (sprite_sel !== 2'd3) begin bad++; $display("FAIL air_sel: got %0d expected 3", sprite_sel); end
    for (int i = 1; i <= 6; i++) begin
      do_tick(1'b0, 1'b1, 1'b1);
      total++; if (sprite_sel !== 2'd1) begin bad++; $display("FAIL reentry_sel[%0d]: got %0d expected 1", i, sprite_sel); end
    end
    do_tick(1'b0, 1'b1, 1'b1);
    total++; if (sprite_sel !== 2'd2) begin bad++; $display("FAIL reentry_step: got %0d expected 2", sprite_sel); end
    do_tick(1'b1, 1'b1, 1'b1);
    total++; if (sprite_sel !== 2'd0) begin bad++; $display("FAIL both_sel: got %0d expected 0", sprite_sel); end
    total++; if (facing_left !== 1'b0) begin bad++; $display("FAIL both_face: got %0d expected 0", facing_left); end
  endtask

  task automatic test_address;
    do_tick(1'b1, 1'b0, 1'b1);
    total++; if (facing_left !== 1'b1) begin bad++; $display("FAIL left_face: got %0d expected 1", facing_left); end
    set_raster(10'd100, 10'd51, 10'd100, 10'd50);
    total++; if (in_sprite !== 1'b1) begin bad++; $display("FAIL mirror_in: got %0d expected 1", in_sprite); end
    total++; if (rom_addr !== 10'd63) begin bad++; $display("FAIL mirror_addr: got %0d expected 63", rom_addr); end
    do_tick(1'b0, 1'b1, 1'b1);
    total++; if (facing_left !== 1'b0) begin bad++; $display("FAIL right_face: got %0d expected 0", facing_left); end
    set_raster(10'd100, 10'd51, 10'd100, 10'd50);
    total++; if (in_sprite !== 1'b1) begin bad++; $display("FAIL plain_in: got %0d expected 1", in_sprite); end
    total++; if (rom_addr !== 10'd32) begin bad++; $display("FAIL plain_addr: got %0d expected 32", rom_addr); end
    set_raster(10'd132, 10'd51, 10'd100, 10'd50);
    total++; if (in_sprite !== 1'b0) begin bad++; $display("FAIL right_edge_in: got %0d expected 0", in_sprite); end
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL right_edge_addr: got %0d expected 0", rom_addr); end
    set_raster(10'd131, 10'd81, 10'd100, 10'd50);
    total++; if (in_sprite !== 1'b1) begin bad++; $display("FAIL corner_in: got %0d expected 1", in_sprite); end
    total++; if (rom_addr !== 10'd1023) begin bad++; $display("FAIL corner_addr: got %0d expected 1023", rom_addr); end
    set_raster(10'd110, 10'd82, 10'd100, 10'd50);
    total++; if (in_sprite !== 1'b0) begin bad++; $display("FAIL bottom_edge_in: got %0d expected 0", in_sprite); end
  endtask

  task automatic test_edge_nowrap;
    set_raster(10'd1023, 10'd0, 10'd1000, 10'd0);
    total++; if (in_sprite !== 1'b1) begin bad++; $display("FAIL far_in: got %0d expected 1", in_sprite); end
    total++; if (rom_addr !== 10'd23) begin bad++; $display("FAIL far_addr: got %0d expected 23", rom_addr); end
    set_raster(10'd5, 10'd0, 10'd1000, 10'd0);
    total++; if (in_sprite !== 1'b0) begin bad++; $display("FAIL nowrap_in: got %0d expected 0", in_sprite); end
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL nowrap_addr: got %0d expected 0", rom_addr); end
  endtask

  task automatic test_async_reset;
    do_tick(1'b1, 1'b0, 1'b1);
    set_raster(10'd100, 10'd51, 10'd100, 10'd50);
    total++; if (in_sprite !== 1'b1 || facing_left !== 1'b1 || sprite_sel !== 2'd1) begin
      bad++; $display("FAIL pre_reset_state: got in=%0d face=%0d sel=%0d expected 1 1 1", in_sprite, facing_left, sprite_sel);
    end
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    total++; if (sprite_sel !== 2'd0) begin bad++; $display("FAIL async_sel: got %0d expected 0", sprite_sel); end
    total++; if (facing_left !== 1'b0) begin bad++; $display("FAIL async_face: got %0d expected 0", facing_left); end
    total++; if (in_sprite !== 1'b0) begin bad++; $display("FAIL async_in: got %0d expected 0", in_sprite); end
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL async_addr: got %0d expected 0", rom_addr); end
    // a tick during reset is overridden
    @(negedge Clk);
    left = 1'b0; right = 1'b1; on_ground = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    total++; if (sprite_sel !== 2'd0) begin bad++; $display("FAIL reset_dominates: got %0d expected 0", sprite_sel); end
    Reset_n = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    total++; if (sprite_sel !== 2'd1) begin bad++; $display("FAIL release_tick_sel: got %0d expected 1", sprite_sel); end
    total++; if (facing_left !== 1'b0) begin bad++; $display("FAIL release_tick_face: got %0d expected 0", facing_left); end
  endtask

  initial begin
    test_reset();
    test_run_cycle();
    test_air_reentry();
    test_address();
    test_edge_nowrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_anim_ctrl.md
# sprite_anim_ctrl

Animation sequencer and sprite-address generator for one fighter sprite. Once per video frame it chooses which pose (idle, run1, run2, air) is drawn, selecting the matching sprite ROM and 16-entry colour palette pair. Every pixel clock it produces the ROM address of the pixel under the raster, mirrored when the fighter faces left. It sits between the game-logic movement block and the sprite ROM/palette lookup in the draw path.

## Interface
- SPRITE_W, 32: sprite width in pixels (power of two)
- SPRITE_H, 32: sprite height in pixels
- FRAMES_PER_STEP, 6: video frames each run pose is held (≥2)
- ADDR_W, 10: ROM address width, log2(SPRITE_W*SPRITE_H)

- Clk  in  1  pixel/system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vblank
- left  in  1  move-left held (sampled only on frame_tick)
- right  in  1  move-right held (sampled only on frame_tick)
- on_ground  in  1  fighter grounded (sampled only on frame_tick)
- DrawX  in  10  current raster column
- DrawY  in  10  current raster row
- PosX  in  10  sprite top-left column
- PosY  in  10  sprite top-left row
- sprite_sel  out  2  pose/bank select: 0 idle, 1 run1, 2 run2, 3 air
- facing_left  out  1  1 = horizontally mirrored
- in_sprite  out  1  raster pixel lies inside sprite box
- rom_addr  out  ADDR_W  sprite ROM address of raster pixel

## Operation
- State register {IDLE, RUN1, RUN2, AIR}; sprite_sel is the registered state encoding (0,1,2,3).
- Step counter, width ⌈log2 FRAMES_PER_STEP⌉.
- State, counter and facing change only on cycles with frame_tick=1; otherwise they hold.
- On frame_tick, first matching rule wins:
  - on_ground=0: go to AIR, clear counter.
  - left XOR right = 1: from IDLE or AIR, go to RUN1 and clear counter. In RUN1/RUN2: if counter = FRAMES_PER_STEP-1, toggle RUN1↔RUN2 and clear; else increment.
  - otherwise (no input, or both held): go to IDLE, clear counter.
- facing_left on frame_tick:
  - set to 1 if left & !right.
  - clear to 0 if right & !left.
  - else hold. It updates in the air too.
- Address path, one register stage:
  - dx = DrawX − PosX, dy = DrawY − PosY.
  - Hit = DrawX ≥ PosX and DrawX < PosX+SPRITE_W and DrawY ≥ PosY and DrawY < PosY+SPRITE_H.
  - Compare sums are 11 bits wide, so boxes near column/row 1023 never wrap to low coordinates.
  - col = facing_left ? SPRITE_W−1−dx : dx.
  - rom_addr = dy·SPRITE_W + col. Since SPRITE_W is a power of two, this is a concatenation.
  - No hit: in_sprite=0, rom_addr=0.
- Mirroring uses the registered facing_left, so it never changes mid-frame.

## Timing
- Reset (Reset_n=0, asynchronous): sprite_sel=0 (IDLE), counter=0, facing_left=0, in_sprite=0, rom_addr=0. These values appear immediately, without a clock edge.
- Reset dominates a coincident frame_tick. The first tick after release is evaluated normally.
- sprite_sel and facing_left update on the clock edge ending the frame_tick cycle. They are stable for the whole following frame.
- in_sprite and rom_addr have a latency of 1 cycle from DrawX/DrawY/PosX/PosY. The draw path delays DrawX/DrawY by one cycle to match.
- Each run pose lasts exactly FRAMES_PER_STEP ticks.
- Leaving RUN1/RUN2 for any reason discards the counter. Re-entry always starts at RUN1, counter 0.
- left/right/on_ground are ignored between ticks.

## Test plan
- Reset, then on_ground=1 with no input for 3 ticks -> sprite_sel=0, facing_left=0 throughout.
- FRAMES_PER_STEP=6, right=1, on_ground=1:
  - ticks 1–6 -> sprite_sel=1
  - ticks 7–12 -> 2
  - tick 13 -> 1
  - facing_left=0 throughout.
- Running in RUN2:
  - on_ground=0 at next tick -> sprite_sel=3.
  - Then on_ground=1 with right held -> sprite_sel=1 for 6 ticks.
  - Then left=right=1 -> sprite_sel=0, facing_left unchanged.
- left=1 tick, then PosX=100, PosY=50, DrawX=100, DrawY=51 -> one cycle later in_sprite=1, rom_addr=63.
  - Same with right facing -> rom_addr=32.
  - DrawX=132 -> in_sprite=0, rom_addr=0.
- Right facing, PosX=1000, PosY=0:
  - DrawX=1023, DrawY=0 -> in_sprite=1, rom_addr=23.
  - DrawX=5 -> in_sprite=0 (no wrap).
- Assert Reset_n=0 mid-run between clock edges -> sprite_sel=0, facing_left=0, in_sprite=0 before the next edge.
  - Release on a cycle with frame_tick=1 and right=1 -> sprite_sel=1 after that edge.
